// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and checks them against expected values.
// Optional SYSID_CHECKER_AUTOSTART_EN: run one check automatically on the first clock edge after reset.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1362923971,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic        master_waitrequest,
  input  logic [31:0] master_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        go, accept, to_hit, auto_pend;

`ifdef SYSID_CHECKER_AUTOSTART_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) auto_pend <= 1'b1;
    else       auto_pend <= 1'b0;
  end
`else
  assign auto_pend = 1'b0;
`endif

  assign go   = start | auto_pend;
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Read strobe and address are decoded from the state register only, so they
  // move on clock edges and fall immediately on an asynchronous reset.
  always_comb begin
    state_nxt      = state;
    master_read    = 1'b0;
    master_address = 32'd0;
    accept         = 1'b0;
    to_hit         = 1'b0;
    case (state)
      IDLE: if (go) state_nxt = RD_ID;
      RD_ID, RD_TS: begin
        master_read    = 1'b1;
        master_address = (state == RD_ID) ? BASE_ADDR : BASE_ADDR + 32'd4;
        if (!master_waitrequest) begin
          accept    = 1'b1;
          state_nxt = (state == RD_ID) ? RD_TS : FINISH;
        end else if (wait_cnt == TIMEOUT_CYCLES - 16'd1) begin
          to_hit    = 1'b1;
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
      wait_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: if (go) begin
          id_ok    <= 1'b0;
          ts_ok    <= 1'b0;
          timeout  <= 1'b0;
          id_value <= 32'd0;
          ts_value <= 32'd0;
          wait_cnt <= 16'd0;
        end
        RD_ID, RD_TS: begin
          if (accept) begin
            wait_cnt <= 16'd0;
            if (state == RD_ID) begin
              id_value <= master_readdata;
              id_ok    <= (master_readdata == EXPECTED_ID);
            end else begin
              ts_value <= master_readdata;
              ts_ok    <= (master_readdata == EXPECTED_TS);
            end
          end else if (to_hit) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
